// File: rtl/rom_arbiter.sv
// Two-port Wishbone-classic read arbiter in front of a single-port synchronous-read ROM.
// Port A (instruction fetch) and port B (data master) are served round robin; B writes get err.
module rom_arbiter #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  a_cyc_i,
  input  logic                  a_stb_i,
  input  logic [ADDR_WIDTH-1:0] a_adr_i,
  output logic [DATA_WIDTH-1:0] a_dat_o,
  output logic                  a_ack_o,
  input  logic                  b_cyc_i,
  input  logic                  b_stb_i,
  input  logic                  b_we_i,
  input  logic [ADDR_WIDTH-1:0] b_adr_i,
  output logic [DATA_WIDTH-1:0] b_dat_o,
  output logic                  b_ack_o,
  output logic                  b_err_o,
  output logic [ADDR_WIDTH-1:0] rom_address,
  output logic                  rom_cen,
  input  logic [DATA_WIDTH-1:0] rom_q
);

  // Handshake: a transfer is requested while cyc & stb are high and completes in the
  // single cycle where ack (or err) is high; the master must keep stb up through that
  // cycle or the completion is dropped without retry.

  logic ack_a_q;
  logic ack_b_q;
  logic err_b_q;
  logic last_grant_b;

  logic a_req;
  logic b_req;
  logic b_write;
  logic a_elig;
  logic b_elig;
  logic grant_a;
  logic grant_b;

  assign a_req   = a_cyc_i & a_stb_i;
  assign b_req   = b_cyc_i & b_stb_i;
  assign b_write = b_req & b_we_i;

  // A port still holding stb in its completion cycle is presenting the finished
  // transfer, so it is not eligible again until the following cycle.
  assign a_elig = a_req & ~ack_a_q;
  assign b_elig = b_req & ~b_we_i & ~ack_b_q & ~err_b_q;

  assign grant_a = a_elig & (~b_elig | last_grant_b);
  assign grant_b = b_elig & (~a_elig | ~last_grant_b);

  always_comb begin
    rom_cen     = 1'b0;
    rom_address = last_grant_b ? b_adr_i : a_adr_i;
    if (reset) begin
      rom_address = '0;
    end else if (grant_a) begin
      rom_cen     = 1'b1;
      rom_address = a_adr_i;
    end else if (grant_b) begin
      rom_cen     = 1'b1;
      rom_address = b_adr_i;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ack_a_q      <= 1'b0;
      ack_b_q      <= 1'b0;
      err_b_q      <= 1'b0;
      last_grant_b <= 1'b1;
    end else begin
      ack_a_q <= grant_a;
      ack_b_q <= grant_b;
      err_b_q <= b_write & ~err_b_q;
      if (grant_a) begin
        last_grant_b <= 1'b0;
      end else if (grant_b) begin
        last_grant_b <= 1'b1;
      end
    end
  end

  assign a_ack_o = ack_a_q & a_req;
  assign b_ack_o = ack_b_q & b_req;
  assign b_err_o = err_b_q & b_req;
  assign a_dat_o = rom_q;
  assign b_dat_o = rom_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: behavioural ROM, per-port expected-data queues popped on ack,
// and cycle-exact checks of grant, address and completion timing per scenario.
module tb_rom_arbiter;
  localparam int AW = 13;
  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          a_cyc_i, a_stb_i;
  logic [AW-1:0] a_adr_i;
  logic [DW-1:0] a_dat_o;
  logic          a_ack_o;
  logic          b_cyc_i, b_stb_i, b_we_i;
  logic [AW-1:0] b_adr_i;
  logic [DW-1:0] b_dat_o;
  logic          b_ack_o, b_err_o;
  logic [AW-1:0] rom_address;
  logic          rom_cen;
  logic [DW-1:0] rom_q;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] exp_a_q[$];
  logic [DW-1:0] exp_b_q[$];
  logic [DW-1:0] exp_d;
  int checks = 0;
  int failures = 0;

  rom_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset),
    .a_cyc_i(a_cyc_i), .a_stb_i(a_stb_i), .a_adr_i(a_adr_i), .a_dat_o(a_dat_o), .a_ack_o(a_ack_o),
    .b_cyc_i(b_cyc_i), .b_stb_i(b_stb_i), .b_we_i(b_we_i), .b_adr_i(b_adr_i), .b_dat_o(b_dat_o),
    .b_ack_o(b_ack_o), .b_err_o(b_err_o),
    .rom_address(rom_address), .rom_cen(rom_cen), .rom_q(rom_q)
  );

  // clock / reset / ROM model
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (rom_cen) rom_q <= mem[rom_address];
  end

  // scoreboard: every ack must match the oldest expected word for that port
  always @(negedge clock) begin
    if (a_ack_o) begin
      checks++;
      if (exp_a_q.size() == 0) begin
        failures++; $display("FAIL a_unexpected_ack: got ack data %h expected no ack", a_dat_o);
      end else begin
        exp_d = exp_a_q.pop_front();
        if (a_dat_o !== exp_d) begin
          failures++; $display("FAIL a_data: got %h expected %h", a_dat_o, exp_d);
        end
      end
    end
    if (b_ack_o) begin
      checks++;
      if (exp_b_q.size() == 0) begin
        failures++; $display("FAIL b_unexpected_ack: got ack data %h expected no ack", b_dat_o);
      end else begin
        exp_d = exp_b_q.pop_front();
        if (b_dat_o !== exp_d) begin
          failures++; $display("FAIL b_data: got %h expected %h", b_dat_o, exp_d);
        end
      end
    end
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge clock); #1;
  endtask

  task automatic drive_idle();
    a_cyc_i = 0; a_stb_i = 0; b_cyc_i = 0; b_stb_i = 0; b_we_i = 0;
  endtask

  task automatic check_drained(input string tag);
    checks++;
    if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: got %0d/%0d pending acks expected 0/0", tag, exp_a_q.size(), exp_b_q.size());
    end
    exp_a_q.delete(); exp_b_q.delete();
  endtask

  task automatic test_reset();
    reset = 1; drive_idle();
    a_cyc_i = 1; a_stb_i = 1; a_adr_i = 13'h1FFF;
    next_cycle(); next_cycle();
    @(negedge clock);
    checks++; if (rom_cen !== 1'b0) begin failures++; $display("FAIL reset_cen: got %b expected 0", rom_cen); end
    checks++; if (rom_address !== 13'h0) begin failures++; $display("FAIL reset_addr: got %h expected 0000", rom_address); end
    checks++; if (a_ack_o !== 1'b0) begin failures++; $display("FAIL reset_ack: got %b expected 0", a_ack_o); end
    next_cycle(); drive_idle(); reset = 0;
    check_drained("reset");
  endtask

  task automatic test_single_a();
    next_cycle(); a_cyc_i = 1; a_stb_i = 1; a_adr_i = 13'h0000;
    @(negedge clock);
    checks++; if (rom_cen !== 1'b1 || rom_address !== 13'h0) begin failures++; $display("FAIL single_grant0: got cen=%b adr=%h expected cen=1 adr=0000", rom_cen, rom_address); end
    exp_a_q.push_back(mem[0]);
    next_cycle(); @(negedge clock);
    checks++; if (a_ack_o !== 1'b1) begin failures++; $display("FAIL single_ack1: got %b expected 1", a_ack_o); end
    checks++; if (rom_cen !== 1'b0) begin failures++; $display("FAIL single_nogrant1: got cen=%b expected 0", rom_cen); end
    next_cycle(); @(negedge clock);
    checks++; if (rom_cen !== 1'b1) begin failures++; $display("FAIL single_grant2: got cen=%b expected 1", rom_cen); end
    exp_a_q.push_back(mem[0]);
    next_cycle(); @(negedge clock);
    checks++; if (a_ack_o !== 1'b1) begin failures++; $display("FAIL single_ack3: got %b expected 1", a_ack_o); end
    next_cycle(); drive_idle(); @(negedge clock);
    checks++; if (rom_cen !== 1'b0) begin failures++; $display("FAIL single_idle: got cen=%b expected 0", rom_cen); end
    check_drained("single");
  endtask

  // both ports hold their strobe for n cycles starting from a state where B won last
  task automatic test_contend(input logic [AW-1:0] aa, input logic [AW-1:0] ba, input int n);
    logic [AW-1:0] ea;
    for (int i = 0; i < n; i++) begin
      next_cycle();
      a_cyc_i = 1; a_stb_i = 1; a_adr_i = aa;
      b_cyc_i = 1; b_stb_i = 1; b_we_i = 0; b_adr_i = ba;
      @(negedge clock);
      ea = (i % 2 == 0) ? aa : ba;
      checks++;
      if (rom_cen !== 1'b1 || rom_address !== ea) begin
        failures++; $display("FAIL contend_c%0d: got cen=%b adr=%h expected cen=1 adr=%h", i, rom_cen, rom_address, ea);
      end
      if (i % 2 == 0) exp_a_q.push_back(mem[aa]); else exp_b_q.push_back(mem[ba]);
    end
    next_cycle(); a_cyc_i = 0; a_stb_i = 0; @(negedge clock);
    checks++; if (rom_cen !== 1'b0) begin failures++; $display("FAIL contend_tail: got cen=%b expected 0", rom_cen); end
    next_cycle(); drive_idle(); @(negedge clock);
    check_drained("contend");
  endtask

  task automatic test_b_write();
    next_cycle(); b_cyc_i = 1; b_stb_i = 1; b_we_i = 1; b_adr_i = 13'h0100;
    @(negedge clock);
    checks++; if (rom_cen !== 1'b0 || b_err_o !== 1'b0) begin failures++; $display("FAIL wr_c0: got cen=%b err=%b expected 0/0", rom_cen, b_err_o); end
    next_cycle(); @(negedge clock);
    checks++; if (b_err_o !== 1'b1 || b_ack_o !== 1'b0 || rom_cen !== 1'b0) begin failures++; $display("FAIL wr_c1: got err=%b ack=%b cen=%b expected 1/0/0", b_err_o, b_ack_o, rom_cen); end
    next_cycle(); @(negedge clock);
    checks++; if (b_err_o !== 1'b0 || rom_cen !== 1'b0) begin failures++; $display("FAIL wr_c2: got err=%b cen=%b expected 0/0", b_err_o, rom_cen); end
    next_cycle(); drive_idle();
    next_cycle(); b_cyc_i = 1; b_stb_i = 1; b_we_i = 1; a_cyc_i = 1; a_stb_i = 1; a_adr_i = 13'h1FFF;
    @(negedge clock);
    checks++; if (rom_cen !== 1'b1 || rom_address !== 13'h1FFF || b_err_o !== 1'b0) begin failures++; $display("FAIL wr_mix0: got cen=%b adr=%h err=%b expected 1/1fff/0", rom_cen, rom_address, b_err_o); end
    exp_a_q.push_back(mem[13'h1FFF]);
    next_cycle(); @(negedge clock);
    checks++; if (b_err_o !== 1'b1 || a_ack_o !== 1'b1 || rom_cen !== 1'b0) begin failures++; $display("FAIL wr_mix1: got err=%b aack=%b cen=%b expected 1/1/0", b_err_o, a_ack_o, rom_cen); end
    next_cycle(); drive_idle(); @(negedge clock);
    check_drained("write");
  endtask

  task automatic test_abort();
    next_cycle(); a_cyc_i = 1; a_stb_i = 1; a_adr_i = 13'h0020;
    @(negedge clock);
    checks++; if (rom_cen !== 1'b1 || rom_address !== 13'h0020) begin failures++; $display("FAIL abort_grant: got cen=%b adr=%h expected 1/0020", rom_cen, rom_address); end
    next_cycle(); a_stb_i = 0; @(negedge clock);
    checks++; if (a_ack_o !== 1'b0 || rom_cen !== 1'b0) begin failures++; $display("FAIL abort_ack: got ack=%b cen=%b expected 0/0", a_ack_o, rom_cen); end
    next_cycle(); a_stb_i = 1; a_adr_i = 13'h0030; @(negedge clock);
    checks++; if (rom_cen !== 1'b1 || rom_address !== 13'h0030) begin failures++; $display("FAIL abort_regrant: got cen=%b adr=%h expected 1/0030", rom_cen, rom_address); end
    exp_a_q.push_back(mem[13'h0030]);
    next_cycle(); @(negedge clock);
    checks++; if (a_ack_o !== 1'b1) begin failures++; $display("FAIL abort_ack2: got %b expected 1", a_ack_o); end
    next_cycle(); drive_idle(); @(negedge clock);
    check_drained("abort");
  endtask

  task automatic test_reset_in_ack();
    next_cycle(); b_cyc_i = 1; b_stb_i = 1; b_we_i = 0; b_adr_i = 13'h0040;
    @(negedge clock);
    checks++; if (rom_cen !== 1'b1 || rom_address !== 13'h0040) begin failures++; $display("FAIL rstack_grant: got cen=%b adr=%h expected 1/0040", rom_cen, rom_address); end
    exp_b_q.push_back(mem[13'h0040]);
    next_cycle(); reset = 1; @(negedge clock);
    checks++; if (rom_cen !== 1'b0 || rom_address !== 13'h0) begin failures++; $display("FAIL rstack_force: got cen=%b adr=%h expected 0/0000", rom_cen, rom_address); end
    next_cycle(); @(negedge clock);
    checks++; if (b_ack_o !== 1'b0 || rom_cen !== 1'b0) begin failures++; $display("FAIL rstack_cleared: got ack=%b cen=%b expected 0/0", b_ack_o, rom_cen); end
    next_cycle(); reset = 0; a_cyc_i = 1; a_stb_i = 1; a_adr_i = 13'h0050; b_adr_i = 13'h0060;
    @(negedge clock);
    checks++; if (rom_cen !== 1'b1 || rom_address !== 13'h0050 || b_ack_o !== 1'b0) begin failures++; $display("FAIL rstack_tie: got cen=%b adr=%h back=%b expected 1/0050/0", rom_cen, rom_address, b_ack_o); end
    exp_a_q.push_back(mem[13'h0050]);
    next_cycle(); @(negedge clock);
    checks++; if (rom_address !== 13'h0060) begin failures++; $display("FAIL rstack_b: got adr=%h expected 0060", rom_address); end
    exp_b_q.push_back(mem[13'h0060]);
    next_cycle(); a_cyc_i = 0; a_stb_i = 0; @(negedge clock);
    next_cycle(); drive_idle(); @(negedge clock);
    check_drained("rstack");
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i * 7) ^ 16'hC3A5;
    mem[0] = 16'h1234; mem[13'h0010] = 16'hAAAA; mem[13'h1FFF] = 16'h5555;
    a_adr_i = '0; b_adr_i = '0; drive_idle(); reset = 1;

    test_reset();
    test_single_a();
    test_reset();
    test_contend(13'h0010, 13'h1FFF, 6);
    test_reset();
    test_b_write();
    test_reset();
    test_abort();
    test_reset();
    test_reset_in_ack();
    test_reset();
    test_contend(13'h0000, 13'h1FFF, 4);
    test_reset();
    test_contend(13'h1FFF, 13'h0000, 4);
    test_reset();
    test_contend(AW'($urandom_range(0, 8191)), AW'($urandom_range(0, 8191)), 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Shares one single-port, synchronous-read 8Kx16 program ROM (1-cycle read latency, read-enable gated) between two Wishbone-classic read requesters.
- Port A: J1 instruction fetch. Port B: a data-side Wishbone master.
- Drives the ROM address and enable, and returns ROM data with per-port ack.
- Writes on port B are refused with err.

Parameters:
- ADDR_WIDTH, 13, ROM word-address width (8192 words).
- DATA_WIDTH, 16, ROM word width.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- a_cyc_i  in  1  port A bus cycle.
- a_stb_i  in  1  port A strobe; request = a_cyc_i & a_stb_i.
- a_adr_i  in  ADDR_WIDTH  port A word address.
- a_dat_o  out  DATA_WIDTH  port A read data, valid only while a_ack_o=1.
- a_ack_o  out  1  port A acknowledge.
- b_cyc_i  in  1  port B bus cycle.
- b_stb_i  in  1  port B strobe.
- b_we_i  in  1  port B write enable (illegal; answered with err).
- b_adr_i  in  ADDR_WIDTH  port B word address.
- b_dat_o  out  DATA_WIDTH  port B read data, valid only while b_ack_o=1.
- b_ack_o  out  1  port B read acknowledge.
- b_err_o  out  1  port B error (write attempt).
- rom_address  out  ADDR_WIDTH  to ROM address.
- rom_cen  out  1  to ROM read enable.
- rom_q  in  DATA_WIDTH  from ROM data; valid the cycle after rom_cen=1.

Behaviour:
- Reset (synchronous, reset=1 at an edge):
  - Clears ack_a_q, ack_b_q, err_b_q and last_grant (=B, so A wins the first tie).
  - While reset=1, rom_cen=0 and rom_address=0 (combinationally forced).
  - Any ack/err that would have followed an in-flight access is discarded.
- Eligibility in cycle N:
  - A is eligible if a_cyc_i & a_stb_i & ~ack_a_q.
  - B read is eligible if b_cyc_i & b_stb_i & ~b_we_i & ~ack_b_q & ~err_b_q.
  - Rationale: a port holding stb during its ack cycle is still presenting the completed transfer, so it must not be re-accepted. Per-port throughput is therefore at most 1 transfer per 2 cycles.
- Arbitration (combinational, cycle N):
  - Only one eligible: grant it.
  - Both eligible: grant the port opposite last_grant (round robin).
  - Granted port: rom_address = its adr, rom_cen=1, last_grant updated at the edge.
  - No grant: rom_cen=0, rom_address holds its last granted value (registered mux select; no X).
- Completion:
  - ack_x_q is set at the edge ending grant cycle N and is high for exactly cycle N+1.
  - x_ack_o = ack_x_q & x_cyc_i & x_stb_i. An aborted strobe suppresses the ack; the data is dropped and there is no retry.
  - a_dat_o = b_dat_o = rom_q, unregistered. Valid only with the corresponding ack.
- Write on B:
  - b_cyc_i & b_stb_i & b_we_i & ~err_b_q sets err_b_q for one cycle.
  - b_err_o = err_b_q & b_cyc_i & b_stb_i.
  - No ROM access occurs and arbitration is unaffected; A may be granted in the same cycle.
- Simultaneous events:
  - A granted while B is in its ack cycle: legal (both ack regs are independent).
  - Both ports assert continuously: grants alternate A,B,A,B; each port sees an ack every 2nd cycle and rom_cen stays 1 every cycle.
- Latency: request to ack = 1 cycle if uncontended, 2 cycles if it loses the tie once. Worst case under contention is bounded at 2 cycles.
- No other state; no FSM beyond last_grant and the three 1-cycle completion flags.

Test Plan:
- Reset, then A alone requests adr 0x0000 with ROM preloaded mem[0]=0x1234 → rom_cen=1 with rom_address=0x0000 in cycle 0; a_ack_o=1 and a_dat_o=0x1234 in cycle 1; no grant in cycle 1; next A grant in cycle 2.
- A (adr 0x0010, mem=0xAAAA) and B (adr 0x1FFF, mem=0x5555) request together after reset, holding stb → A acked first with 0xAAAA, then B with 0x5555, then A again. rom_cen is continuously 1, and rom_address alternates 0x0010/0x1FFF.
- B write (b_we_i=1, adr 0x0100) → b_err_o=1 for one cycle the next cycle; b_ack_o=0; rom_cen=0 throughout; a concurrent A read still completes normally.
- A granted in cycle N, then a_stb_i dropped in cycle N+1 → a_ack_o stays 0; a new A request in N+2 is accepted.
- reset asserted in the ack cycle of a B read → b_ack_o=0 on the following cycles; rom_cen=0 while reset=1; the first post-reset tie goes to A.
- Boundary addresses 0x0000 and 0x1FFF on both ports → correct data; no address wrap or truncation.
